// File: rtl/serial_add_ctrl_if.sv
// Requester-side bundle for serial_add_ctrl: start/operands in, busy/done/result out.
// Carries ovf only when OVF_DETECT_EN is defined.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef OVF_DETECT_EN
    logic             ovf;

    modport master (
        output start, op_a, op_b, cin,
        input  busy, done, sum, cout, ovf
    );
    modport slave (
        input  start, op_a, op_b, cin,
        output busy, done, sum, cout, ovf
    );
`else
    modport master (
        output start, op_a, op_b, cin,
        input  busy, done, sum, cout
    );
    modport slave (
        input  start, op_a, op_b, cin,
        output busy, done, sum, cout
    );
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add controller time-sharing one external full adder, LSB first.
// Optional signed overflow flag when OVF_DETECT_EN is defined.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_add_ctrl_if.slave  bus,
    output logic              fa_a,
    output logic              fa_b,
    output logic              fa_cin,
    input  logic              fa_s,
    input  logic              fa_cout
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nxt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             run;
    logic             last;

    assign run     = (state == S_RUN);
    assign last    = run && (cnt == CW'(WIDTH - 1));
    assign res_nxt = {fa_s, res[WIDTH-1:1]};

    // Adder is purely combinational; gate its inputs off outside RUN.
    assign fa_a   = run & a_sr[0];
    assign fa_b   = run & b_sr[0];
    assign fa_cin = run & carry;

    assign bus.busy = (state != S_IDLE);
    assign bus.done = (state == S_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            unique case (1'b1)
                (state == S_IDLE): begin
                    if (bus.start) begin
                        a_sr  <= bus.op_a;
                        b_sr  <= bus.op_b;
                        carry <= bus.cin;
                        cnt   <= '0;
                        state <= S_RUN;
                    end
                end
                run: begin
                    res   <= res_nxt;
                    carry <= fa_cout;
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        state  <= S_DONE;
                        sum_q  <= res_nxt;
                        cout_q <= fa_cout;
                    end
                end
                (state == S_DONE): begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef OVF_DETECT_EN
    logic ovf_q;

    assign bus.ovf = ovf_q;

    // On the MSB cycle the carry flop holds the carry into the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (last) begin
            ovf_q <= carry ^ fa_cout;
        end
    end
`endif
endmodule
